ram_port_sequencer: RTL and testbench
=====================================

Name: ram_port_sequencer

Overview:
- Command-driven controller that owns the single port of the `ram` block and sits directly upstream of it.
- Executes three bulk operations on a contiguous, wrapping address window:
  - FILL: stream words in and write them.
  - DUMP: read words and stream them out.
  - CLEAR: zero-fill.
- Lets the rest of the design move blocks of data through `ram` with valid/ready handshakes instead of driving `write`/`address` directly.

Parameters:
- ADDRESS_BITS, 4, width of the RAM address; DEPTH = 2**ADDRESS_BITS.
- DATA_BITS, 8, RAM word width.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  2  01=FILL, 10=DUMP, 11=CLEAR, 00=NOP.
- cmd_base  input  ADDRESS_BITS  first address.
- cmd_count  input  ADDRESS_BITS+1  number of words.
- in_valid  input  1  FILL data offered.
- in_ready  output  1  FILL data accepted.
- in_data  input  DATA_BITS  FILL word.
- out_valid  output  1  DUMP word available.
- out_ready  input  1  DUMP consumer ready.
- out_data  output  DATA_BITS  DUMP word.
- ram_write  output  1  to ram write.
- ram_address  output  ADDRESS_BITS  to ram address.
- ram_data_in  output  DATA_BITS  to ram data_in.
- ram_data_out  input  DATA_BITS  from ram data_out; valid one cycle after the address is presented.
- busy  output  1  high whenever not IDLE.
- done  output  1  one-cycle pulse on command completion.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE; addr=0, remaining=0, out_data=0.
  - Outputs: out_valid=0, done=0, busy=0, ram_write=0, ram_address=0, ram_data_in=0, in_ready=0.
  - cmd_ready=1 once reset is released.
  - Reset mid-operation abandons the command with no done pulse. RAM contents already written are left as-is.
- **States:** IDLE, FILL, CLEAR, RD_ADDR, RD_DATA, RD_HOLD.
- **IDLE:**
  - Command is accepted on cmd_valid && cmd_ready.
  - Load addr=cmd_base and remaining=min(cmd_count, DEPTH).
  - If the op is NOP or remaining==0: stay in IDLE and pulse done next cycle.
  - Otherwise go to FILL, RD_ADDR or CLEAR per cmd_op.
- **FILL:**
  - in_ready=1.
  - ram_write=in_valid (combinational), ram_address=addr, ram_data_in=in_data.
  - On handshake: addr=addr+1 mod DEPTH, remaining-=1.
  - Final handshake (remaining==1) → IDLE, with done high the following cycle.
  - in_valid low: no write, no advance.
- **CLEAR:**
  - ram_write=1, ram_data_in=0, ram_address=addr every cycle.
  - Advance as in FILL, one word per cycle, no handshake.
  - Exits to IDLE with done after the last word.
- **DUMP (ram_write=0 throughout):**
  - RD_ADDR: ram_address=addr; → RD_DATA.
  - RD_DATA: ram_data_out is valid; capture it into out_data; → RD_HOLD.
  - RD_HOLD: out_valid=1 and out_data stable until out_ready.
  - On the RD_HOLD handshake: addr+1 mod DEPTH, remaining-=1; → RD_ADDR, or → IDLE with done if this was the last word.
  - Minimum throughput is 3 cycles/word.
- **Address and count rules:**
  - Address wrap: DEPTH-1 → 0. The window may straddle the top of memory.
  - cmd_count > DEPTH is clamped to DEPTH, so no address is written twice within one command.
- **Handshake exclusivity:**
  - Only one of cmd_ready, in_ready and out_valid is ever high at a time.
  - in_valid outside FILL and out_ready outside RD_HOLD are ignored.
- **done:**
  - Registered; high exactly one cycle, the cycle after the final transfer (or after acceptance for NOP/zero count).
  - cmd_ready is already 1 in that cycle, so back-to-back commands are allowed.
- **ram_address in IDLE:** holds its last value; only ram_write=0 is guaranteed.

Decomposition:
- Shared package: op encodings (OP_NOP, OP_FILL, OP_DUMP, OP_CLEAR), the state enumeration, and a DEPTH function of ADDRESS_BITS.
- No sub-module. The address/remaining counter pair stays inline; it is too small to justify one.
- The testbench instantiates ram_port_sequencer wired to `ram`.

Test Plan:
1. ADDRESS_BITS=4, DATA_BITS=8. FILL base=0, count=4, in_data 0x11, 0x22, 0x33, 0x44 with no stalls → ram_write high 4 consecutive cycles at addresses 0–3; done pulses once; a following DUMP base=0, count=4 returns 0x11..0x44 in order.
2. FILL base=14, count=4 with data A0..A3 → writes land at 14, 15, 0, 1; DUMP base=14, count=4 returns A0..A3 (wrap-around).
3. CLEAR base=0, count=20 → clamped to 16; ram_write high exactly 16 cycles with data 0; a subsequent DUMP of 16 words yields all zeros.
4. DUMP count=3 with out_ready held low for 5 cycles on word 2 → out_valid and out_data stay stable while stalled; no RAM address advance; 3 words delivered, then done.
5. cmd_count=0 FILL, then NOP → no ram_write, done pulses one cycle after each acceptance; cmd_ready stays 1.
6. Assert reset low mid-FILL after 2 of 5 words → outputs go to reset values immediately, no done pulse; after release a new DUMP of addresses 0–1 returns the 2 words already written.

Source files
------------

// File: rtl/ram_port_sequencer_pkg.sv
// ram_port_sequencer_pkg
// Shared definitions for the RAM port sequencer: command opcodes, the
// controller state enumeration and the RAM depth helper.
package ram_port_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FILL  = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CLEAR,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_HOLD
    } state_e;

    // Number of words addressable with address_bits address lines.
    function automatic int unsigned depth_f(input int unsigned address_bits);
        return 32'd1 << address_bits;
    endfunction

endpackage

// File: rtl/ram.sv
// ram
// Single-port synchronous RAM. A write happens on the rising clock edge
// when write is high; data_out is registered and presents the word at the
// address of the previous cycle.
// Ports: clock, write, address, data_in, data_out.
module ram #(
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clock,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_BITS-1:0]    data_in,
    output logic [DATA_BITS-1:0]    data_out
);

    logic [DATA_BITS-1:0] mem_q [2**ADDRESS_BITS];

    always_ff @(posedge clock) begin
        if (write) begin
            mem_q[address] <= data_in;
        end
        data_out <= mem_q[address];
    end

endmodule

// File: rtl/ram_port_sequencer.sv
// ram_port_sequencer
// Owns the single port of a synchronous RAM and runs bulk FILL, DUMP and
// CLEAR operations over a contiguous address window that wraps at DEPTH.
// Ports:
//   clock, reset (async, active low)
//   cmd_*     : command channel (valid/ready), op, base address, word count
//   in_*      : FILL data stream (valid/ready)
//   out_*     : DUMP data stream (valid/ready)
//   ram_*     : RAM port (write, address, data_in, data_out)
//   busy      : high whenever not idle
//   done      : one-cycle registered pulse on command completion
module ram_port_sequencer
    import ram_port_sequencer_pkg::*;
#(
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDRESS_BITS-1:0] cmd_base,
    input  logic [ADDRESS_BITS:0]   cmd_count,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_BITS-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_BITS-1:0]    out_data,
    output logic                    ram_write,
    output logic [ADDRESS_BITS-1:0] ram_address,
    output logic [DATA_BITS-1:0]    ram_data_in,
    input  logic [DATA_BITS-1:0]    ram_data_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned           DEPTH   = depth_f(ADDRESS_BITS);
    localparam logic [ADDRESS_BITS:0] DEPTH_W = (ADDRESS_BITS+1)'(DEPTH);
    localparam logic [ADDRESS_BITS:0] ONE_W   = (ADDRESS_BITS+1)'(1);

    state_e                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [ADDRESS_BITS:0]   rem_q, rem_d;
    logic [DATA_BITS-1:0]    out_data_q, out_data_d;
    logic                    done_q, done_d;
    logic [ADDRESS_BITS:0]   count_clamped;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    assign count_clamped = (cmd_count > DEPTH_W) ? DEPTH_W : cmd_count;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        ram_write   = 1'b0;
        ram_data_in = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_base;
                    rem_d  = count_clamped;
                    if (op_e'(cmd_op) == OP_NOP || count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        unique case (op_e'(cmd_op))
                            OP_FILL:  state_d = ST_FILL;
                            OP_DUMP:  state_d = ST_RD_ADDR;
                            OP_CLEAR: state_d = ST_CLEAR;
                            default:  state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_FILL: begin
                ram_write   = in_valid;
                ram_data_in = in_data;
                if (in_valid) begin
                    addr_d = addr_q + ADDRESS_BITS'(1);
                    rem_d  = rem_q - ONE_W;
                    if (rem_q == ONE_W) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                ram_write = 1'b1;
                addr_d    = addr_q + ADDRESS_BITS'(1);
                rem_d     = rem_q - ONE_W;
                if (rem_q == ONE_W) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // RAM output is registered: the word for addr_q appears now.
                out_data_d = ram_data_out;
                state_d    = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (out_ready) begin
                    addr_d = addr_q + ADDRESS_BITS'(1);
                    rem_d  = rem_q - ONE_W;
                    if (rem_q == ONE_W) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_address = addr_q;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign in_ready    = (state_q == ST_FILL);
    assign out_valid   = (state_q == ST_RD_HOLD);
    assign out_data    = out_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_ram_port_sequencer.sv
// tb_ram_port_sequencer
// Directed bench: ram_port_sequencer wired to ram, exercising FILL, DUMP
// (with stall), CLEAR with count clamp, address wrap, zero-count/NOP
// commands and reset in the middle of a FILL.
module tb_ram_port_sequencer;

    localparam int AB = 4;
    localparam int DB = 8;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AB-1:0] cmd_base;
    logic [AB:0]   cmd_count;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DB-1:0] out_data;
    logic          ram_write;
    logic [AB-1:0] ram_address;
    logic [DB-1:0] ram_data_in;
    logic [DB-1:0] ram_data_out;
    logic          busy;
    logic          done;

    int unsigned   total;
    int unsigned   passed;
    logic [DB-1:0] vec [16];

    ram_port_sequencer #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_base     (cmd_base),
        .cmd_count    (cmd_count),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ram_write    (ram_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy),
        .done         (done)
    );

    ram #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) u_ram (
        .clock    (clock),
        .write    (ram_write),
        .address  (ram_address),
        .data_in  (ram_data_in),
        .data_out (ram_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Offer a command at a falling edge; accepted at the following rising edge.
    task automatic send_cmd(input logic [1:0] op, input logic [AB-1:0] base, input logic [AB:0] count);
        @(negedge clock);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_count = count;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic check_done();
        check("done_pulse", 32'(done), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
        check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        check("done_single", 32'(done), 32'd0);
    endtask

    // FILL n words from vec[]; stall_idx >= 0 inserts one idle cycle before that word.
    task automatic do_fill(input logic [AB-1:0] base, input int n, input int stall_idx);
        logic [AB-1:0] a;
        send_cmd(2'b01, base, (AB+1)'(n));
        for (int i = 0; i < n; i++) begin
            a = base + AB'(i);
            if (i == stall_idx) begin
                @(negedge clock);
                in_valid = 1'b0;
                #1;
                check("fill_stall_nowrite", 32'(ram_write), 32'd0);
                check("fill_stall_inready", 32'(in_ready), 32'd1);
                check("fill_stall_addr", 32'(ram_address), 32'(a));
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = vec[i];
            #1;
            check("fill_in_ready", 32'(in_ready), 32'd1);
            check("fill_write", 32'(ram_write), 32'd1);
            check("fill_addr", 32'(ram_address), 32'(a));
            check("fill_data", 32'(ram_data_in), 32'(vec[i]));
            check("fill_excl", 32'({cmd_ready, out_valid}), 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("fill_end_nowrite", 32'(ram_write), 32'd0);
        check_done();
    endtask

    // DUMP n words expecting vec[]; stall_cycles of out_ready low on word stall_idx.
    task automatic do_dump(input logic [AB-1:0] base, input int n, input int stall_idx, input int stall_cycles);
        logic [AB-1:0] a;
        send_cmd(2'b10, base, (AB+1)'(n));
        for (int i = 0; i < n; i++) begin
            a = base + AB'(i);
            @(negedge clock);
            check("rd_addr_addr", 32'(ram_address), 32'(a));
            check("rd_addr_nowrite", 32'(ram_write), 32'd0);
            check("rd_addr_novalid", 32'(out_valid), 32'd0);
            @(negedge clock);
            check("rd_data_novalid", 32'(out_valid), 32'd0);
            @(negedge clock);
            check("rd_hold_valid", 32'(out_valid), 32'd1);
            check("rd_hold_data", 32'(out_data), 32'(vec[i]));
            check("rd_hold_excl", 32'({cmd_ready, in_ready}), 32'd0);
            if (i == stall_idx) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clock);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(vec[i]));
                    check("stall_addr", 32'(ram_address), 32'(a));
                end
            end
            out_ready = 1'b1;
            @(posedge clock);
            #1 out_ready = 1'b0;
        end
        @(negedge clock);
        check("dump_end_novalid", 32'(out_valid), 32'd0);
        check_done();
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_base  = '0;
        cmd_count = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_write", 32'(ram_write), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_din", 32'(ram_data_in), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: FILL 0..3 then DUMP
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        do_fill(4'd0, 4, -1);
        do_dump(4'd0, 4, -1, 0);

        // 2: wrap-around window 14,15,0,1 with one input stall
        vec[0] = 8'hA0; vec[1] = 8'hA1; vec[2] = 8'hA2; vec[3] = 8'hA3;
        do_fill(4'd14, 4, 2);
        do_dump(4'd14, 4, -1, 0);

        // 3: CLEAR with count 20 clamped to 16
        send_cmd(2'b11, 4'd0, 5'd20);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("clr_write", 32'(ram_write), 32'd1);
            check("clr_data", 32'(ram_data_in), 32'd0);
            check("clr_addr", 32'(ram_address), 32'(i));
        end
        @(negedge clock);
        check("clr_end_nowrite", 32'(ram_write), 32'd0);
        check_done();
        for (int i = 0; i < 16; i++) vec[i] = 8'h00;
        do_dump(4'd0, 16, -1, 0);

        // 4: DUMP of 3 with word 2 stalled for 5 cycles
        vec[0] = 8'h71; vec[1] = 8'h72; vec[2] = 8'h73;
        do_fill(4'd5, 3, -1);
        do_dump(4'd5, 3, 1, 5);

        // 5: zero-count FILL, then NOP
        send_cmd(2'b01, 4'd3, 5'd0);
        @(negedge clock);
        check("zero_nowrite", 32'(ram_write), 32'd0);
        check_done();
        send_cmd(2'b00, 4'd7, 5'd4);
        @(negedge clock);
        check("nop_nowrite", 32'(ram_write), 32'd0);
        check_done();

        // 6: reset after 2 of 5 FILL words
        send_cmd(2'b01, 4'd0, 5'd5);
        @(negedge clock);
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clock);
        in_data = 8'hC3;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_write", 32'(ram_write), 32'd0);
        check("mid_rst_addr", 32'(ram_address), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clock);
        #1;
        check("mid_rst_no_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("post_rst_done", 32'(done), 32'd0);
        vec[0] = 8'h5A; vec[1] = 8'hC3;
        do_dump(4'd0, 2, -1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: observed no finish expected finish");
    end

endmodule
